pipelined_addsub: RTL



---
 rtl/pipelined_addsub_if.sv | 27 ++
 rtl/pipelined_addsub.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// master drives operands and result acceptance; slave is the add/sub unit.
interface pipelined_addsub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             sub;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, sub, x, y, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, sub, x, y, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one CHUNK of the carry chain per stage, carry registered between stages.
// Optional signed saturation of the result when ADDSUB_SAT_EN is defined.
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_addsub_if.slave  bus
);
    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    // Per-stage state: operands travel forward, partial result accumulates, carry chains on.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] r_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] r_d [STAGES];
    logic             c_d [STAGES];
    logic             v_d [STAGES];
    logic             ovf_q;
    logic             ovf_d;
    logic             zero_q;
    logic             zero_d;
    logic             stall;

    assign stall         = v_q[LAST] && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = v_q[LAST];
    assign bus.s         = r_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    // Next value of every stage; a stage only loads data when its source beat is valid.
    always_comb begin : stage_next
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_r;
        logic [WIDTH-1:0] res;
        logic             src_c;
        logic             src_v;
        logic             cin_msb;
        logic [CHUNK:0]   sum_c;

        ovf_d   = ovf_q;
        zero_d  = zero_q;
        cin_msb = 1'b0;
        src_a   = bus.x;
        src_b   = bus.sub ? ~bus.y : bus.y;
        src_c   = bus.sub;
        src_r   = '0;
        src_v   = bus.in_valid;

        for (int unsigned i = 0; i < STAGES; i++) begin
            sum_c = (CHUNK+1)'(src_a[i*CHUNK +: CHUNK])
                  + (CHUNK+1)'(src_b[i*CHUNK +: CHUNK])
                  + (CHUNK+1)'(src_c);
            res = src_r;
            res[i*CHUNK +: CHUNK] = sum_c[CHUNK-1:0];

            v_d[i] = src_v;
            a_d[i] = a_q[i];
            b_d[i] = b_q[i];
            c_d[i] = c_q[i];
            r_d[i] = r_q[i];

            if (src_v) begin
                a_d[i] = src_a;
                b_d[i] = src_b;
                c_d[i] = sum_c[CHUNK];
                r_d[i] = res;
                if (i == LAST) begin
                    // Carry into the MSB recovered from the MSB sum bit and its operands.
                    cin_msb = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ res[WIDTH-1];
                    ovf_d   = cin_msb ^ sum_c[CHUNK];
`ifdef ADDSUB_SAT_EN
                    if (ovf_d) begin
                        r_d[i] = src_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                    zero_d  = ~|r_d[i];
                end
            end

            src_a = a_q[i];
            src_b = b_q[i];
            src_c = c_q[i];
            src_r = r_q[i];
            src_v = v_q[i];
        end
    end

    // Whole pipeline advances together and freezes on output stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                v_q[i] <= 1'b0;
                a_q[i] <= '0;
                b_q[i] <= '0;
                r_q[i] <= '0;
                c_q[i] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                v_q[i] <= v_d[i];
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
                r_q[i] <= r_d[i];
                c_q[i] <= c_d[i];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end
endmodule
